// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared aluop codes, opcode/funct constants, state and decode types
package multicycle_ctrl_pkg;

  localparam logic [3:0] ALUOP_ADDU = 4'd0;
  localparam logic [3:0] ALUOP_SUBU = 4'd1;
  localparam logic [3:0] ALUOP_AND  = 4'd2;
  localparam logic [3:0] ALUOP_OR   = 4'd3;
  localparam logic [3:0] ALUOP_SLT  = 4'd4;
  localparam logic [3:0] ALUOP_LW   = 4'd5;
  localparam logic [3:0] ALUOP_SW   = 4'd6;
  localparam logic [3:0] ALUOP_ADDI = 4'd7;
  localparam logic [3:0] ALUOP_ANDI = 4'd8;
  localparam logic [3:0] ALUOP_ORI  = 4'd9;
  localparam logic [3:0] ALUOP_BEQ  = 4'd10;
  localparam logic [3:0] ALUOP_BNE  = 4'd11;
  localparam logic [3:0] ALUOP_LUI  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_RS   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;
  localparam logic [1:0] SRC_B_IMM2 = 2'd3;
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_EXEC_R, ST_WB_R, ST_EXEC_I, ST_WB_I, ST_MEM_ADDR,
    ST_MEM_RD, ST_WB_M, ST_MEM_WR, ST_BRANCH, ST_JUMP, ST_ILLEGAL
  } state_e;

  typedef enum logic [2:0] {CL_R, CL_I, CL_MEM, CL_BR, CL_J, CL_ILL} iclass_e;

  typedef struct packed {
    iclass_e    iclass;
    logic [3:0] aluop;
    logic       ext_sign;
    logic       legal;
  } decode_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct decode into class, aluop, extension and legality
module mc_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output decode_t    dec
);

  // Classify the instruction; anything unrecognised falls through as illegal
  always_comb begin
    dec = '{iclass: CL_ILL, aluop: ALUOP_ADDU, ext_sign: 1'b0, legal: 1'b0};
    case (opcode)
      OP_RTYPE: begin
        dec.iclass = CL_R;
        dec.legal  = 1'b1;
        case (funct)
          FN_ADDU: dec.aluop = ALUOP_ADDU;
          FN_SUBU: dec.aluop = ALUOP_SUBU;
          FN_AND:  dec.aluop = ALUOP_AND;
          FN_OR:   dec.aluop = ALUOP_OR;
          FN_SLT:  dec.aluop = ALUOP_SLT;
          default: begin
            dec.iclass = CL_ILL;
            dec.legal  = 1'b0;
          end
        endcase
      end
      OP_ADDI: dec = '{iclass: CL_I,   aluop: ALUOP_ADDI, ext_sign: 1'b1, legal: 1'b1};
      OP_ANDI: dec = '{iclass: CL_I,   aluop: ALUOP_ANDI, ext_sign: 1'b0, legal: 1'b1};
      OP_ORI:  dec = '{iclass: CL_I,   aluop: ALUOP_ORI,  ext_sign: 1'b0, legal: 1'b1};
      OP_LUI:  dec = '{iclass: CL_I,   aluop: ALUOP_LUI,  ext_sign: 1'b0, legal: 1'b1};
      OP_LW:   dec = '{iclass: CL_MEM, aluop: ALUOP_LW,   ext_sign: 1'b1, legal: 1'b1};
      OP_SW:   dec = '{iclass: CL_MEM, aluop: ALUOP_SW,   ext_sign: 1'b1, legal: 1'b1};
      OP_BEQ:  dec = '{iclass: CL_BR,  aluop: ALUOP_BEQ,  ext_sign: 1'b1, legal: 1'b1};
      OP_BNE:  dec = '{iclass: CL_BR,  aluop: ALUOP_BNE,  ext_sign: 1'b1, legal: 1'b1};
      OP_J:    dec = '{iclass: CL_J,   aluop: ALUOP_ADDU, ext_sign: 1'b0, legal: 1'b1};
      default: dec = '{iclass: CL_ILL, aluop: ALUOP_ADDU, ext_sign: 1'b0, legal: 1'b0};
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS control FSM driving ALU control, operand selects and strobes
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [3:0]       alu_ctrl,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_sign,
  output logic             ir_write,
  output logic             pc_en,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt
);

  state_e  state;
  state_e  next_state;
  decode_t dec;
  logic    retire;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

  // State register, sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_FETCH;
      illegal    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state <= next_state;
      if (next_state == ST_ILLEGAL) illegal <= 1'b1;
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // Next-state selection; retire marks the last cycle of each completed instruction
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      ST_FETCH:    if (mem_ready) next_state = ST_DECODE;
      ST_DECODE: begin
        if (!dec.legal) next_state = ST_ILLEGAL;
        else begin
          case (dec.iclass)
            CL_R:    next_state = ST_EXEC_R;
            CL_I:    next_state = ST_EXEC_I;
            CL_MEM:  next_state = ST_MEM_ADDR;
            CL_BR:   next_state = ST_BRANCH;
            CL_J:    next_state = ST_JUMP;
            default: next_state = ST_ILLEGAL;
          endcase
        end
      end
      ST_EXEC_R:   next_state = ST_WB_R;
      ST_EXEC_I:   next_state = ST_WB_I;
      ST_MEM_ADDR: next_state = (dec.aluop == ALUOP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) next_state = ST_WB_M;
      ST_MEM_WR: begin
        if (mem_ready) begin
          next_state = ST_FETCH;
          retire     = 1'b1;
        end
      end
      ST_WB_R, ST_WB_I, ST_WB_M, ST_BRANCH, ST_JUMP: begin
        next_state = ST_FETCH;
        retire     = 1'b1;
      end
      ST_ILLEGAL:  next_state = ST_ILLEGAL;
      default:     next_state = ST_FETCH;
    endcase
  end

  // Output decode from state; only pc_en and ir_write also look at mem_ready/alu_zero
  always_comb begin
    alu_ctrl   = ALUOP_ADDU;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RT;
    ext_sign   = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = PC_SRC_ALU;
    if (reset_n) begin
      case (state)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        ST_DECODE: begin
          alu_src_b = SRC_B_IMM2;
          ext_sign  = 1'b1;
        end
        ST_EXEC_R: begin
          alu_ctrl  = dec.aluop;
          alu_src_a = SRC_A_RS;
        end
        ST_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        ST_EXEC_I: begin
          alu_ctrl  = dec.aluop;
          alu_src_a = (dec.aluop == ALUOP_LUI) ? SRC_A_ZERO : SRC_A_RS;
          alu_src_b = SRC_B_IMM;
          ext_sign  = dec.ext_sign;
        end
        ST_WB_I:     reg_write = 1'b1;
        ST_MEM_ADDR: begin
          alu_ctrl  = dec.aluop;
          alu_src_a = SRC_A_RS;
          alu_src_b = SRC_B_IMM;
          ext_sign  = 1'b1;
        end
        ST_MEM_RD:   mem_read = 1'b1;
        ST_WB_M: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        ST_MEM_WR:   mem_write = 1'b1;
        ST_BRANCH: begin
          alu_ctrl  = dec.aluop;
          alu_src_a = SRC_A_RS;
          pc_src    = PC_SRC_ALUOUT;
          pc_en     = (dec.aluop == ALUOP_BEQ) ? alu_zero : ~alu_zero;
        end
        ST_JUMP: begin
          pc_en  = 1'b1;
          pc_src = PC_SRC_JUMP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with directed instruction vectors
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  opcode, funct;
  logic        alu_zero, mem_ready;
  logic [3:0]  alu_ctrl;
  logic [1:0]  alu_src_a, alu_src_b, pc_src;
  logic        ext_sign, ir_write, pc_en, mem_read, mem_write, reg_write;
  logic        reg_dst, mem_to_reg, illegal;
  logic [31:0] retire_cnt;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .alu_ctrl(alu_ctrl),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_sign(ext_sign),
    .ir_write(ir_write), .pc_en(pc_en), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .pc_src(pc_src), .illegal(illegal),
    .retire_cnt(retire_cnt)
  );

  // Expected outputs for one cycle; -1 marks a field left unchecked.
  // strb packs {ir_write, pc_en, mem_read, mem_write, reg_write}.
  typedef struct {
    string name;
    int alu, sa, sb, ext, strb, pcs, rdst, m2r, ill, ret;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int exp_ret = 0;
  int exp_ill = 0;

  task automatic chk(input string nm, input string fld, input int act, input int want);
    if (want >= 0) begin
      checks++;
      if (act != want) begin
        errors++;
        $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, want);
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.name, "alu_ctrl",   int'(alu_ctrl),   e.alu);
      chk(e.name, "alu_src_a",  int'(alu_src_a),  e.sa);
      chk(e.name, "alu_src_b",  int'(alu_src_b),  e.sb);
      chk(e.name, "ext_sign",   int'(ext_sign),   e.ext);
      chk(e.name, "strobes",    int'({ir_write, pc_en, mem_read, mem_write, reg_write}), e.strb);
      chk(e.name, "pc_src",     int'(pc_src),     e.pcs);
      chk(e.name, "reg_dst",    int'(reg_dst),    e.rdst);
      chk(e.name, "mem_to_reg", int'(mem_to_reg), e.m2r);
      chk(e.name, "illegal",    int'(illegal),    e.ill);
      chk(e.name, "retire_cnt", int'(retire_cnt), e.ret);
    end
  end

  task automatic step(input string nm, input logic rdy, input logic z,
                      input int alu, input int sa, input int sb, input int ext,
                      input int strb, input int pcs, input int rdst, input int m2r);
    exp_t e;
    mem_ready = rdy;
    alu_zero  = z;
    e.name = nm; e.alu = alu; e.sa = sa; e.sb = sb; e.ext = ext;
    e.strb = strb; e.pcs = pcs; e.rdst = rdst; e.m2r = m2r;
    e.ill = exp_ill; e.ret = exp_ret;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step("reset", 1'b1, 1'b0, 0, 0, 0, -1, 0, 0, -1, -1);
    reset_n = 1'b1;
    exp_ret = 0;
    exp_ill = 0;
  endtask

  task automatic fetch(input logic rdy);
    step("fetch", rdy, 1'b0, 0, 0, 1, -1, rdy ? 28 : 4, 0, -1, -1);
  endtask

  task automatic decode(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    step("decode", 1'b1, 1'b0, 0, 0, 3, 1, 0, -1, -1, -1);
  endtask

  task automatic run_r(input logic [5:0] fn, input int alu);
    fetch(1'b1);
    decode(6'b000000, fn);
    step("exec_r", 1'b1, 1'b0, alu, 1, 0, -1, 0, -1, -1, -1);
    step("wb_r", 1'b1, 1'b0, -1, -1, -1, -1, 1, -1, 1, 0);
    exp_ret++;
  endtask

  task automatic run_i(input logic [5:0] op, input int alu, input int sa, input int ext);
    fetch(1'b1);
    decode(op, 6'b000000);
    step("exec_i", 1'b1, 1'b0, alu, sa, 2, ext, 0, -1, -1, -1);
    step("wb_i", 1'b1, 1'b0, -1, -1, -1, -1, 1, -1, 0, 0);
    exp_ret++;
  endtask

  task automatic run_lw(input int waits);
    fetch(1'b1);
    decode(6'b100011, 6'b000000);
    step("lw_addr", 1'b1, 1'b0, 5, 1, 2, 1, 0, -1, -1, -1);
    for (int i = 0; i < waits; i++) step("mem_rd_wait", 1'b0, 1'b0, -1, -1, -1, -1, 4, -1, -1, -1);
    step("mem_rd", 1'b1, 1'b0, -1, -1, -1, -1, 4, -1, -1, -1);
    step("wb_m", 1'b1, 1'b0, -1, -1, -1, -1, 1, -1, 0, 1);
    exp_ret++;
  endtask

  task automatic sw_head(input int waits);
    fetch(1'b1);
    decode(6'b101011, 6'b000000);
    step("sw_addr", 1'b1, 1'b0, 6, 1, 2, 1, 0, -1, -1, -1);
    for (int i = 0; i < waits; i++) step("mem_wr_wait", 1'b0, 1'b0, -1, -1, -1, -1, 2, -1, -1, -1);
  endtask

  task automatic run_br(input logic [5:0] op, input logic z, input int alu, input int taken);
    fetch(1'b1);
    decode(op, 6'b000000);
    step("branch", 1'b1, z, alu, 1, 0, -1, taken ? 8 : 0, 1, -1, -1);
    exp_ret++;
  endtask

  initial begin
    reset_n = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0; alu_zero = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    run_r(6'b100001, 0);
    run_r(6'b100011, 1);
    run_r(6'b100100, 2);
    run_r(6'b100101, 3);
    run_r(6'b101010, 4);
    run_lw(3);
    sw_head(0);
    step("mem_wr", 1'b1, 1'b0, -1, -1, -1, -1, 2, -1, -1, -1);
    exp_ret++;
    run_br(6'b000100, 1'b1, 10, 1);
    run_br(6'b000101, 1'b1, 11, 0);
    run_br(6'b000100, 1'b0, 10, 0);
    run_br(6'b000101, 1'b0, 11, 1);
    run_i(6'b001111, 12, 2, 0);
    run_i(6'b001101, 9, 1, 0);
    run_i(6'b001000, 7, 1, 1);
    run_i(6'b001100, 8, 1, 0);
    fetch(1'b0);
    fetch(1'b1);
    decode(6'b000010, 6'b000000);
    step("jump", 1'b1, 1'b0, -1, -1, -1, -1, 8, 2, -1, -1);
    exp_ret++;
    sw_head(2);
    do_reset();
    fetch(1'b0);
    fetch(1'b1);
    decode(6'b111111, 6'b000000);
    exp_ill = 1;
    for (int i = 0; i < 3; i++) step("illegal_op", 1'b1, 1'b1, -1, -1, -1, -1, 0, -1, -1, -1);
    do_reset();
    fetch(1'b1);
    decode(6'b000000, 6'b100000);
    exp_ill = 1;
    for (int i = 0; i < 2; i++) step("illegal_fn", 1'b1, 1'b0, -1, -1, -1, -1, 0, -1, -1, -1);
    do_reset();
    run_r(6'b100001, 0);
    fetch(1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
